// File: rtl/bus_dev_pkg.sv
// rtl/bus_dev_pkg.sv - shared constants and helpers for the bus device port
package bus_dev_pkg;

  // Destination-ID field width and the default broadcast address.
  localparam int unsigned ADDR_W = 8;
  localparam logic [ADDR_W-1:0] BCAST_DEFAULT = 8'b0000_0110;

  // Widest packet the address helper can accept.
  localparam int unsigned PKT_MAX_W = 64;

  // Bit positions inside the sticky error vector.
  localparam int unsigned ERR_TX_OVF = 0;
  localparam int unsigned ERR_TX_UDF = 1;
  localparam int unsigned ERR_RX_OVF = 2;
  localparam int unsigned ERR_RX_UDF = 3;
  localparam int unsigned ERR_W      = 4;

  // Destination ID is the top ADDR_W bits of a packet that is `width` bits
  // wide; the packet is passed zero-extended to PKT_MAX_W.
  function automatic logic [ADDR_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                                input int unsigned        width);
    logic [PKT_MAX_W-1:0] shifted;
    shifted = pkt >> (width - ADDR_W);
    return shifted[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/bus_dev_fifo.sv
// rtl/bus_dev_fifo.sv - show-ahead FIFO with occupancy count and event flags
module bus_dev_fifo
  import bus_dev_pkg::*;
#(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [width-1:0]         wr_data,
  input  logic                     rd,
  output logic [width-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(depth):0]   count,
  output logic                     ovf,
  output logic                     udf
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [width-1:0] mem_q [depth];

  logic do_wr;
  logic do_rd;

  // Status decodes only from the registered count.
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(depth));
  assign count = count_q;

  // A read of an empty FIFO is dropped; a write to a full FIFO is accepted
  // only when a read frees the head slot in the same cycle.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  // One-cycle event pulses; the owner decides whether to make them sticky.
  assign udf = rd && empty;
  assign ovf = wr && !do_wr;

  // Head is masked to zero while empty so stale storage is never exposed.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet storage; contents need no reset because the head is masked.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/bus_dev_port.sv
// rtl/bus_dev_port.sv - per-slot bus endpoint with TX queue and filtered RX queue
module bus_dev_port
  import bus_dev_pkg::*;
#(
  parameter int               pckg_sz   = 16,
  parameter int               depth     = 8,
  parameter logic [7:0]       dev_id    = 8'd0,
  parameter logic [7:0]       broadcast = BCAST_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tx_wr,
  input  logic [pckg_sz-1:0]      tx_data,
  output logic                    tx_full,
  output logic                    pndng,
  output logic [pckg_sz-1:0]      D_pop,
  input  logic                    pop,
  input  logic                    push,
  input  logic [pckg_sz-1:0]      D_push,
  output logic                    rx_valid,
  output logic [pckg_sz-1:0]      rx_data,
  input  logic                    rx_rd,
  output logic [$clog2(depth):0]  tx_count,
  output logic [$clog2(depth):0]  rx_count,
  output logic [7:0]              misaddr_cnt,
  output logic [3:0]              err
);

  logic tx_empty, tx_ovf, tx_udf;
  logic rx_empty, rx_full, rx_ovf, rx_udf;
  logic [ADDR_W-1:0] dest;
  logic addr_match;
  logic rx_push;
  logic [7:0] misaddr_q, misaddr_d;
  logic [ERR_W-1:0] err_q, err_d;

  // Device-to-bus queue.
  bus_dev_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (tx_wr),
    .wr_data (tx_data),
    .rd      (pop),
    .rd_data (D_pop),
    .empty   (tx_empty),
    .full    (tx_full),
    .count   (tx_count),
    .ovf     (tx_ovf),
    .udf     (tx_udf)
  );

  assign pndng = !tx_empty;

  // Only packets addressed to this slot or to everyone enter the RX queue.
  assign dest       = dest_of(PKT_MAX_W'(D_push), pckg_sz);
  assign addr_match = (dest == dev_id) || (dest == broadcast);
  assign rx_push    = push && addr_match;

  // Bus-to-device queue.
  bus_dev_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (rx_push),
    .wr_data (D_push),
    .rd      (rx_rd),
    .rd_data (rx_data),
    .empty   (rx_empty),
    .full    (rx_full),
    .count   (rx_count),
    .ovf     (rx_ovf),
    .udf     (rx_udf)
  );

  assign rx_valid = !rx_empty;

  // Misaddressed-drop counter saturates; sticky error bits accumulate events.
  always_comb begin
    misaddr_d = misaddr_q;
    if (push && !addr_match && (misaddr_q != 8'hFF)) misaddr_d = misaddr_q + 8'd1;
    err_d = err_q;
    err_d[ERR_TX_OVF] = err_q[ERR_TX_OVF] | tx_ovf;
    err_d[ERR_TX_UDF] = err_q[ERR_TX_UDF] | tx_udf;
    err_d[ERR_RX_OVF] = err_q[ERR_RX_OVF] | rx_ovf;
    err_d[ERR_RX_UDF] = err_q[ERR_RX_UDF] | rx_udf;
  end

  // Status registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misaddr_q <= '0;
      err_q     <= '0;
    end else begin
      misaddr_q <= misaddr_d;
      err_q     <= err_d;
    end
  end

  assign misaddr_cnt = misaddr_q;
  assign err         = err_q;

endmodule

// File: tb/tb_bus_dev_port.sv
// tb/tb_bus_dev_port.sv - directed vector bench for bus_dev_port
module tb_bus_dev_port;

  logic        clk;
  logic        reset;
  logic        tx_wr;
  logic [15:0] tx_data;
  logic        tx_full;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_rd;
  logic [3:0]  tx_count;
  logic [3:0]  rx_count;
  logic [7:0]  misaddr_cnt;
  logic [3:0]  err;

  int total = 0;
  int bad   = 0;

  bus_dev_port #(.pckg_sz(16), .depth(8), .dev_id(8'd2), .broadcast(8'h06)) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_wr       (tx_wr),
    .tx_data     (tx_data),
    .tx_full     (tx_full),
    .pndng       (pndng),
    .D_pop       (D_pop),
    .pop         (pop),
    .push        (push),
    .D_push      (D_push),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_rd       (rx_rd),
    .tx_count    (tx_count),
    .rx_count    (rx_count),
    .misaddr_cnt (misaddr_cnt),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tx_wr;
    logic [15:0] tx_data;
    logic        pop;
    logic        push;
    logic [15:0] d_push;
    logic        rx_rd;
    logic        e_pndng;
    logic [15:0] e_d_pop;
    logic [3:0]  e_tx_count;
    logic        e_rx_valid;
    logic [15:0] e_rx_data;
    logic [3:0]  e_rx_count;
    logic [7:0]  e_misaddr;
    logic [3:0]  e_err;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [15:0] wd, input logic p,
                     input logic ps, input logic [15:0] pd, input logic r);
    tx_wr = w; tx_data = wd; pop = p; push = ps; D_push = pd; rx_rd = r;
    @(posedge clk);
    #1;
    tx_wr = 0; tx_data = 0; pop = 0; push = 0; D_push = 0; rx_rd = 0;
  endtask

  task automatic async_reset();
    #3;
    reset = 0;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // tx_wr tx_data pop push d_push rx_rd | pndng d_pop txc rxv rx_data rxc mis err
    vecs[0]  = '{1'b1, 16'h0A11, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0A11, 4'd1, 1'b0, 16'h0000, 4'd0, 8'd0, 4'h0};
    vecs[1]  = '{1'b1, 16'h0B22, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0A11, 4'd2, 1'b0, 16'h0000, 4'd0, 8'd0, 4'h0};
    vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0B22, 4'd1, 1'b0, 16'h0000, 4'd0, 8'd0, 4'h0};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'd0, 8'd0, 4'h0};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0255, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 16'h0255, 4'd1, 8'd0, 4'h0};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0655, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 16'h0255, 4'd2, 8'd0, 4'h0};
    vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0355, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 16'h0255, 4'd2, 8'd1, 4'h0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b1, 16'h0655, 4'd1, 8'd1, 4'h0};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0277, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b1, 16'h0277, 4'd1, 8'd1, 4'h0};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'd0, 8'd1, 4'h0};
    vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'd0, 8'd1, 4'h8};
    vecs[11] = '{1'b1, 16'h0C33, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0C33, 4'd1, 1'b0, 16'h0000, 4'd0, 8'd1, 4'hA};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'd0, 8'd1, 4'hA};

    reset = 0; tx_wr = 0; tx_data = 0; pop = 0; push = 0; D_push = 0; rx_rd = 0;
    #1;
    check("reset pndng", 32'(pndng), 0);
    check("reset rx_valid", 32'(rx_valid), 0);
    check("reset tx_full", 32'(tx_full), 0);
    check("reset D_pop", 32'(D_pop), 0);
    check("reset rx_data", 32'(rx_data), 0);
    check("reset misaddr", 32'(misaddr_cnt), 0);
    check("reset err", 32'(err), 0);
    release_reset();

    for (int i = 0; i < NV; i++) begin
      tx_wr = vecs[i].tx_wr; tx_data = vecs[i].tx_data; pop = vecs[i].pop;
      push = vecs[i].push; D_push = vecs[i].d_push; rx_rd = vecs[i].rx_rd;
      @(posedge clk);
      #1;
      check($sformatf("v%0d pndng", i),    32'(pndng),       32'(vecs[i].e_pndng));
      check($sformatf("v%0d D_pop", i),    32'(D_pop),       32'(vecs[i].e_d_pop));
      check($sformatf("v%0d tx_count", i), 32'(tx_count),    32'(vecs[i].e_tx_count));
      check($sformatf("v%0d rx_valid", i), 32'(rx_valid),    32'(vecs[i].e_rx_valid));
      check($sformatf("v%0d rx_data", i),  32'(rx_data),     32'(vecs[i].e_rx_data));
      check($sformatf("v%0d rx_count", i), 32'(rx_count),    32'(vecs[i].e_rx_count));
      check($sformatf("v%0d misaddr", i),  32'(misaddr_cnt), 32'(vecs[i].e_misaddr));
      check($sformatf("v%0d err", i),      32'(err),         32'(vecs[i].e_err));
    end
    tx_wr = 0; tx_data = 0; pop = 0; push = 0; D_push = 0; rx_rd = 0;

    // Asynchronous reset with three packets queued and errors pending.
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0D00 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
    check("pre-reset tx_count", 32'(tx_count), 3);
    async_reset();
    check("async pndng", 32'(pndng), 0);
    check("async tx_count", 32'(tx_count), 0);
    check("async err", 32'(err), 0);
    check("async D_pop", 32'(D_pop), 0);
    check("async misaddr", 32'(misaddr_cnt), 0);
    release_reset();

    // Fill TX, simultaneous write+pop while full, then overflow.
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
    check("fill tx_full", 32'(tx_full), 1);
    check("fill tx_count", 32'(tx_count), 8);
    check("fill D_pop", 32'(D_pop), 32'h1000);
    cyc(1'b1, 16'h1008, 1'b1, 1'b0, 16'h0, 1'b0);
    check("wr+pop full tx_count", 32'(tx_count), 8);
    check("wr+pop full err", 32'(err), 0);
    check("wr+pop full D_pop", 32'(D_pop), 32'h1001);
    cyc(1'b1, 16'h1FFF, 1'b0, 1'b0, 16'h0, 1'b0);
    check("ovf err", 32'(err), 1);
    check("ovf tx_count", 32'(tx_count), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain %0d D_pop", i), 32'(D_pop), 32'h1001 + 32'(i));
      cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    end
    check("drained pndng", 32'(pndng), 0);
    check("drained tx_full", 32'(tx_full), 0);
    check("drained D_pop", 32'(D_pop), 0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("tx udf err", 32'(err), 32'h3);
    async_reset();
    release_reset();

    // Misaddressed-push counter saturation.
    for (int i = 0; i < 255; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0300 + 16'(i & 8'hFF), 1'b0);
    check("mis 255", 32'(misaddr_cnt), 255);
    for (int i = 0; i < 45; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'hF000 + 16'(i), 1'b0);
    check("mis sat", 32'(misaddr_cnt), 255);
    check("mis rx_count", 32'(rx_count), 0);
    check("mis rx_valid", 32'(rx_valid), 0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0699, 1'b0);
    check("bcast after sat rx_count", 32'(rx_count), 1);
    check("bcast after sat rx_data", 32'(rx_data), 32'h0699);
    check("bcast after sat mis", 32'(misaddr_cnt), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
